// File: rtl/seq_detect_param_if.sv
// Serial bit-stream bundle for seq_detect_param.
// master: drives in/in_valid/overlap/clr_cnt; slave: returns out/match_cnt/progress.
interface seq_detect_param_if #(
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 8
);
  localparam int SW = $clog2(PAT_LEN);

  logic             in;
  logic             in_valid;
  logic             overlap;
  logic             clr_cnt;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic [SW-1:0]    progress;

  modport master (
    output in, in_valid, overlap, clr_cnt,
    input  out, match_cnt, progress
  );

  modport slave (
    input  in, in_valid, overlap, clr_cnt,
    output out, match_cnt, progress
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector (KMP automaton built at elaboration).
// Ports: clk, rst (sync, active-high), bus (slave: in/in_valid/overlap/clr_cnt -> out/match_cnt/progress).
module seq_detect_param #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_param_if.slave  bus
);
  localparam int SW = $clog2(PAT_LEN);
  localparam int NS = 1 << SW;

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad
    $fatal(1, "seq_detect_param: PAT_LEN must be 2..16");
  end

  // Next matched-prefix length after bit b in state s.
  // Returns PAT_LEN when b completes the pattern.
  function automatic int nxt_fn(int s, logic b);
    logic [16:0] seq;
    int          res;
    logic        ok;
    seq = '0;
    res = 0;
    if (b == PATTERN[PAT_LEN-1-s]) begin
      res = s + 1;
    end else begin
      for (int i = 0; i < s; i++)
        seq[i] = PATTERN[PAT_LEN-1-i];
      seq[s] = b;
      // ascending scan keeps the longest border
      for (int k = 1; k <= s; k++) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (seq[s+1-k+i] != PATTERN[PAT_LEN-1-i])
            ok = 1'b0;
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Longest proper border of the whole pattern.
  function automatic int border_fn();
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (PATTERN[k-1-i] != PATTERN[PAT_LEN-1-i])
          ok = 1'b0;
      if (ok) res = k;
    end
    return res;
  endfunction

  localparam logic [SW-1:0] F = SW'(border_fn());

  logic [SW-1:0] nx0 [NS];
  logic [SW-1:0] nx1 [NS];
  logic [NS-1:0] hit0;
  logic [NS-1:0] hit1;

  for (genvar s = 0; s < NS; s++) begin : g_tbl
    if (s < PAT_LEN) begin : g_v
      localparam int N0 = nxt_fn(s, 1'b0);
      localparam int N1 = nxt_fn(s, 1'b1);
      localparam int V0 = (N0 >= PAT_LEN) ? 0 : N0;
      localparam int V1 = (N1 >= PAT_LEN) ? 0 : N1;
      assign nx0[s]  = SW'(V0);
      assign nx1[s]  = SW'(V1);
      assign hit0[s] = (N0 >= PAT_LEN);
      assign hit1[s] = (N1 >= PAT_LEN);
    end else begin : g_x
      assign nx0[s]  = '0;
      assign nx1[s]  = '0;
      assign hit0[s] = 1'b0;
      assign hit1[s] = 1'b0;
    end
  end

  logic [SW-1:0]    state_q, state_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
  logic [SW-1:0]    nxt;

  always_comb begin
    hit = bus.in ? hit1[state_q] : hit0[state_q];
    nxt = bus.in ? nx1[state_q] : nx0[state_q];
  end

  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    cnt_d   = cnt_q;
    if (bus.in_valid) begin
      if (hit) begin
        out_d   = 1'b1;
        state_d = bus.overlap ? F : '0;
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = nxt;
      end
    end
    if (bus.clr_cnt)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.progress  = state_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed table-driven bench for seq_detect_param.
// Three instances: default, CNT_W=2, and PAT_LEN=4 / 1010.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_LEN(5), .CNT_W(8)) ifa ();
  seq_detect_param_if #(.PAT_LEN(5), .CNT_W(2)) ifb ();
  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(8)) ifc ();

  seq_detect_param #(.PAT_LEN(5), .PATTERN(5'b11011), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa));
  seq_detect_param #(.PAT_LEN(5), .PATTERN(5'b11011), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst_c), .bus(ifc));

  typedef struct {
    logic r;
    logic i;
    logic v;
    logic o;
    logic c;
    logic eo;
    int   ec;
    int   ep;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic r, logic i, logic v, logic o,
                              logic c, logic eo, int ec, int ep);
    vec_t t;
    t.r = r; t.i = i; t.v = v; t.o = o; t.c = c;
    t.eo = eo; t.ec = ec; t.ep = ep;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run(int d, vec_t t, string nm);
    int ao, ac, ap;
    case (d)
      0: begin
        rst_a = t.r; ifa.in = t.i; ifa.in_valid = t.v;
        ifa.overlap = t.o; ifa.clr_cnt = t.c;
      end
      1: begin
        rst_b = t.r; ifb.in = t.i; ifb.in_valid = t.v;
        ifb.overlap = t.o; ifb.clr_cnt = t.c;
      end
      default: begin
        rst_c = t.r; ifc.in = t.i; ifc.in_valid = t.v;
        ifc.overlap = t.o; ifc.clr_cnt = t.c;
      end
    endcase
    @(posedge clk);
    #1;
    case (d)
      0: begin
        ao = int'(ifa.out); ac = int'(ifa.match_cnt); ap = int'(ifa.progress);
      end
      1: begin
        ao = int'(ifb.out); ac = int'(ifb.match_cnt); ap = int'(ifb.progress);
      end
      default: begin
        ao = int'(ifc.out); ac = int'(ifc.match_cnt); ap = int'(ifc.progress);
      end
    endcase
    chk({nm, " out"}, ao, int'(t.eo));
    chk({nm, " cnt"}, ac, t.ec);
    chk({nm, " prog"}, ap, t.ep);
  endtask

  vec_t va[$];
  vec_t vb[$];
  vec_t vc[$];

  initial begin
    int mc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.in = 0; ifa.in_valid = 0; ifa.overlap = 0; ifa.clr_cnt = 0;
    ifb.in = 0; ifb.in_valid = 0; ifb.overlap = 0; ifb.clr_cnt = 0;
    ifc.in = 0; ifc.in_valid = 0; ifc.overlap = 0; ifc.clr_cnt = 0;

    // A: overlap=1, 11011011
    va.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 2));
    va.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4));
    va.push_back(mk(0, 1, 1, 1, 0, 1, 1, 2));
    va.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 1, 4));
    va.push_back(mk(0, 1, 1, 1, 0, 1, 2, 2));
    // A: overlap=0, same stream
    va.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1));
    va.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2));
    va.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3));
    va.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4));
    va.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0));
    va.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    va.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
    va.push_back(mk(0, 1, 1, 0, 0, 0, 1, 2));
    // A: 1101111011 overlap=1
    va.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 2));
    va.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4));
    va.push_back(mk(0, 1, 1, 1, 0, 1, 1, 2));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2));
    va.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 1, 4));
    va.push_back(mk(0, 1, 1, 1, 0, 1, 2, 2));
    // A: idle gap holds partial match
    va.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 2));
    va.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3));
    va.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3));
    va.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4));
    va.push_back(mk(0, 1, 1, 1, 0, 1, 1, 2));
    // A: reset at progress=4 discards partial match
    va.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 1, 4));
    va.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    // A: clr_cnt without match
    va.push_back(mk(0, 1, 1, 1, 1, 0, 0, 2));

    foreach (va[k]) run(0, va[k], $sformatf("A%0d", k));

    // B: CNT_W=2 saturation, then clr on match cycle
    vb.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    vb.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    vb.push_back(mk(0, 1, 1, 1, 0, 0, 0, 2));
    vb.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3));
    vb.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4));
    vb.push_back(mk(0, 1, 1, 1, 0, 1, 1, 2));
    for (int m = 2; m <= 8; m++) begin
      mc = (m > 3) ? 3 : m;
      vb.push_back(mk(0, 0, 1, 1, 0, 0, (m - 1 > 3) ? 3 : m - 1, 3));
      vb.push_back(mk(0, 1, 1, 1, 0, 0, (m - 1 > 3) ? 3 : m - 1, 4));
      vb.push_back(mk(0, 1, 1, 1, 0, 1, mc, 2));
    end
    vb.push_back(mk(0, 0, 1, 1, 0, 0, 3, 3));
    vb.push_back(mk(0, 1, 1, 1, 0, 0, 3, 4));
    vb.push_back(mk(0, 1, 1, 1, 1, 1, 0, 2));
    vb.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3));
    vb.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4));
    vb.push_back(mk(0, 1, 1, 1, 0, 1, 1, 2));

    foreach (vb[k]) run(1, vb[k], $sformatf("B%0d", k));

    // C: PAT_LEN=4, 1010, overlap=1, then mismatch fallbacks
    vc.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    vc.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    vc.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2));
    vc.push_back(mk(0, 1, 1, 1, 0, 0, 0, 3));
    vc.push_back(mk(0, 0, 1, 1, 0, 1, 1, 2));
    vc.push_back(mk(0, 1, 1, 1, 0, 0, 1, 3));
    vc.push_back(mk(0, 0, 1, 1, 0, 1, 2, 2));
    vc.push_back(mk(0, 0, 1, 1, 0, 0, 2, 0));
    vc.push_back(mk(0, 1, 1, 1, 0, 0, 2, 1));
    vc.push_back(mk(0, 1, 1, 1, 0, 0, 2, 1));

    foreach (vc[k]) run(2, vc[k], $sformatf("C%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial sequence detector: the next generation of the team's fixed 11011 Mealy detector. The pattern and its length are parameters. Overlapping or non-overlapping detection is selected at run time. Adds an input qualifier, a saturating match counter and a progress output. It sits on a 1-bit serial stream, with `out` feeding downstream framing/sync logic.

Parameters:
- PAT_LEN, 5, pattern length in bits; legal range 2..16.
- PATTERN, 5'b11011, pattern value, PAT_LEN bits wide; PATTERN[PAT_LEN-1] is the first bit expected on the line.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies `in`; the bit is consumed only when high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on the match cycle.
- clr_cnt  input  1  synchronous clear of match_cnt.
- out  output  1  registered match pulse, one cycle wide.
- match_cnt  output  CNT_W  saturating count of matches.
- progress  output  $clog2(PAT_LEN)  current matched-prefix length, 0..PAT_LEN-1.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clk edge): state/progress=0, out=0, match_cnt=0. rst overrides all other inputs. Reset mid-pattern discards the partial match.
- State encoding: state = length of the longest pattern prefix that is a suffix of the consumed bits. Legal values are 0..PAT_LEN-1; no other states exist.
- Transition on a consumed bit b (in_valid=1):
  - If b equals the pattern bit at index `state` (counted from the MSB), next = state+1.
  - Otherwise, next = length of the longest proper suffix of (matched prefix, b) that is also a pattern prefix. This is the KMP failure function.
  - The transition table is computed from PATTERN at elaboration via a function. There is no runtime table storage.
- Match: the consumed bit completes the full PAT_LEN pattern.
  - out <= 1 on that edge, so `out` is high for the cycle after the edge that sampled the final bit.
  - Next state = F (longest proper border of PATTERN) if overlap=1, else 0. For 11011, F=2.
- Any cycle without a match: out <= 0.
- in_valid=0: state holds, out <= 0, match_cnt holds. Idle cycles never break a partial match.
- match_cnt:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt=1 forces 0. If a match occurs in the same cycle, clr_cnt wins: count=0, but out still pulses.
- overlap may change at any time. Only its value on the match cycle matters.
- progress is the registered state and is combinationally driven from it.
- Width rule: `state` is $clog2(PAT_LEN) bits. No arithmetic exceeds PAT_LEN.
- Elaboration check: PAT_LEN outside 2..16 is a fatal error.

Test Plan:
- Defaults, overlap=1, in_valid=1, stream 1,1,0,1,1,0,1,1 -> out pulses after bit 5 and after bit 8; match_cnt=2; progress=2 after each match.
- Same stream, overlap=0 -> single pulse after bit 5; progress=2 at end; match_cnt=1.
- Stream 1,1,0,1,1,1,1,0,1,1, overlap=1 -> pulses after bits 5 and 10 only; progress stays at 2 through bits 6-7.
- Stream 1,1,0 then in_valid=0 for 3 cycles, then 1,1 -> progress holds at 3 during the gap; single match pulse after the final bit.
- rst=1 asserted with progress=4, then bit 1 -> progress=1, out=0; no match.
- CNT_W=2, eight back-to-back overlapping matches -> match_cnt=3 and holds. Then clr_cnt=1 on a match cycle -> match_cnt=0, out=1.
- PAT_LEN=4, PATTERN=4'b1010, overlap=1, stream 1,0,1,0,1,0 -> pulses after bits 4 and 6.
